// File: rtl/frog_move_controller.sv
// -----------------------------------------------------------------------------
// frog_move_controller
//
// Tile-grid movement controller for the Frogger player sprite. Four debounced
// direction levels are turned into one hop per press, with hold-to-repeat after
// an initial delay. Hops off the grid are refused and reported. Landing on
// row 0 reports a goal. A respawn pulse returns the frog to the start tile.
//
// Ports
//   i_Clk          system clock
//   i_Reset        synchronous, active-high reset
//   i_Enable       1 = movement allowed (game running)
//   i_Respawn      1-cycle pulse: return to the start tile
//   i_Up/Down/Left/Right  debounced direction levels
//   o_Col, o_Row   current tile
//   o_X_Position   o_Col * TILE_SIZE (registered)
//   o_Y_Position   o_Row * TILE_SIZE (registered)
//   o_Move_Pulse   1-cycle pulse per completed hop
//   o_Blocked      1-cycle pulse when a hop is refused at the grid edge
//   o_Goal         1-cycle pulse, with o_Move_Pulse, when a hop lands on row 0
//   o_Fsm_State    debug view of the repeat FSM (0 idle, 1 delay, 2 repeat)
//
// Handshake note: there is no valid/ready traffic here. Direction inputs are
// plain levels, and a hop is requested by the level's rising edge. Every
// output is a registered level or a single-cycle pulse.
// -----------------------------------------------------------------------------
module frog_move_controller #(
    parameter int TILE_SIZE    = 16,
    parameter int GRID_COLS    = 20,
    parameter int GRID_ROWS    = 15,
    parameter int START_COL    = 10,
    parameter int START_ROW    = 12,
    parameter int REPEAT_DELAY = 6000000,
    parameter int REPEAT_RATE  = 3000000,
    parameter int COORD_W      = 9,
    localparam int COL_W = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1,
    localparam int ROW_W = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    input  logic               i_Enable,
    input  logic               i_Respawn,
    input  logic               i_Up,
    input  logic               i_Down,
    input  logic               i_Left,
    input  logic               i_Right,
    output logic [COL_W-1:0]   o_Col,
    output logic [ROW_W-1:0]   o_Row,
    output logic [COORD_W-1:0] o_X_Position,
    output logic [COORD_W-1:0] o_Y_Position,
    output logic               o_Move_Pulse,
    output logic               o_Blocked,
    output logic               o_Goal,
    output logic [1:0]         o_Fsm_State
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]   DELAY_LOAD = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0]   RATE_LOAD  = CNT_W'(REPEAT_RATE - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [COL_W-1:0]   COL_ONE    = COL_W'(1);
    localparam logic [ROW_W-1:0]   ROW_ONE    = ROW_W'(1);
    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(GRID_COLS - 1);
    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(GRID_ROWS - 1);
    localparam logic [COL_W-1:0]   START_C    = COL_W'(START_COL);
    localparam logic [ROW_W-1:0]   START_R    = ROW_W'(START_ROW);
    localparam logic [COORD_W-1:0] START_X    = COORD_W'(START_COL * TILE_SIZE);
    localparam logic [COORD_W-1:0] START_Y    = COORD_W'(START_ROW * TILE_SIZE);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    logic [1:0]       state, state_n;
    logic [1:0]       dir, dir_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       key_hist;

    logic [3:0]       keys;
    logic [3:0]       rise;
    logic [1:0]       new_dir;
    logic             latched_held;
    logic             do_hop;
    logic [1:0]       hop_dir;
    logic [COL_W-1:0] dest_col;
    logic [ROW_W-1:0] dest_row;
    logic             edge_block;

    // Bit order {up, down, left, right}: bit 3 has the highest priority.
    assign keys = {i_Up, i_Down, i_Left, i_Right};
    assign rise = keys & ~key_hist;

    always_comb begin
        new_dir = DIR_RIGHT;
        if (rise[3])      new_dir = DIR_UP;
        else if (rise[2]) new_dir = DIR_DOWN;
        else if (rise[1]) new_dir = DIR_LEFT;
    end

    always_comb begin
        case (dir)
            DIR_UP:   latched_held = keys[3];
            DIR_DOWN: latched_held = keys[2];
            DIR_LEFT: latched_held = keys[1];
            default:  latched_held = keys[0];
        endcase
    end

    // Repeat FSM. A fresh edge always wins. The latched key cannot produce an
    // edge while it is held, so any edge seen in DELAY/REPEAT comes from a
    // different key and overrides the current repeat.
    always_comb begin
        state_n = state;
        dir_n   = dir;
        cnt_n   = cnt;
        do_hop  = 1'b0;
        hop_dir = dir;
        if (!i_Enable) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
        end else if (|rise) begin
            do_hop  = 1'b1;
            hop_dir = new_dir;
            dir_n   = new_dir;
            cnt_n   = DELAY_LOAD;
            state_n = ST_DELAY;
        end else begin
            case (state)
                ST_DELAY, ST_REPEAT: begin
                    if (!latched_held) begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end else if (cnt == '0) begin
                        do_hop  = 1'b1;
                        cnt_n   = RATE_LOAD;
                        state_n = ST_REPEAT;
                    end else begin
                        cnt_n = cnt - CNT_ONE;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // Destination tile for the hop direction. Off-grid hops keep the current tile.
    always_comb begin
        dest_col   = o_Col;
        dest_row   = o_Row;
        edge_block = 1'b0;
        case (hop_dir)
            DIR_UP: begin
                if (o_Row == '0) edge_block = 1'b1;
                else             dest_row   = o_Row - ROW_ONE;
            end
            DIR_DOWN: begin
                if (o_Row == ROW_LAST) edge_block = 1'b1;
                else                   dest_row   = o_Row + ROW_ONE;
            end
            DIR_LEFT: begin
                if (o_Col == '0) edge_block = 1'b1;
                else             dest_col   = o_Col - COL_ONE;
            end
            default: begin
                if (o_Col == COL_LAST) edge_block = 1'b1;
                else                   dest_col   = o_Col + COL_ONE;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_Col        <= START_C;
            o_Row        <= START_R;
            o_X_Position <= START_X;
            o_Y_Position <= START_Y;
            o_Move_Pulse <= 1'b0;
            o_Blocked    <= 1'b0;
            o_Goal       <= 1'b0;
            state        <= ST_IDLE;
            dir          <= DIR_UP;
            cnt          <= '0;
            key_hist     <= '0;
        end else begin
            // History tracks the keys even while disabled or respawning, so a
            // key held across those events does not produce a late hop.
            key_hist     <= keys;
            o_Move_Pulse <= 1'b0;
            o_Blocked    <= 1'b0;
            o_Goal       <= 1'b0;
            if (i_Respawn) begin
                o_Col        <= START_C;
                o_Row        <= START_R;
                o_X_Position <= START_X;
                o_Y_Position <= START_Y;
                state        <= ST_IDLE;
                cnt          <= '0;
            end else begin
                state <= state_n;
                dir   <= dir_n;
                cnt   <= cnt_n;
                if (do_hop) begin
                    if (edge_block) begin
                        o_Blocked <= 1'b1;
                    end else begin
                        o_Col        <= dest_col;
                        o_Row        <= dest_row;
                        o_X_Position <= COORD_W'(32'(dest_col) * TILE_SIZE);
                        o_Y_Position <= COORD_W'(32'(dest_row) * TILE_SIZE);
                        o_Move_Pulse <= 1'b1;
                        o_Goal       <= (dest_row == '0);
                    end
                end
            end
        end
    end

    assign o_Fsm_State = state;

endmodule

// File: tb/tb_frog_move_controller.sv
module tb_frog_move_controller;

    localparam int TILE = 16;
    localparam int COLS = 20;
    localparam int ROWS = 15;
    localparam int SC   = 10;
    localparam int SR   = 12;
    localparam int DLY  = 4;
    localparam int RATE = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       i_Reset, i_Enable, i_Respawn, i_Up, i_Down, i_Left, i_Right;
    logic [4:0] o_Col;
    logic [3:0] o_Row;
    logic [8:0] o_X_Position, o_Y_Position;
    logic       o_Move_Pulse, o_Blocked, o_Goal;
    logic [1:0] o_Fsm_State;

    frog_move_controller #(
        .TILE_SIZE(TILE), .GRID_COLS(COLS), .GRID_ROWS(ROWS),
        .START_COL(SC), .START_ROW(SR),
        .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE), .COORD_W(9)
    ) dut (
        .i_Clk(clk), .i_Reset(i_Reset), .i_Enable(i_Enable), .i_Respawn(i_Respawn),
        .i_Up(i_Up), .i_Down(i_Down), .i_Left(i_Left), .i_Right(i_Right),
        .o_Col(o_Col), .o_Row(o_Row),
        .o_X_Position(o_X_Position), .o_Y_Position(o_Y_Position),
        .o_Move_Pulse(o_Move_Pulse), .o_Blocked(o_Blocked), .o_Goal(o_Goal),
        .o_Fsm_State(o_Fsm_State)
    );

    int checks = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    // Tracks the frog on the grid and schedules auto-repeat hops by absolute
    // cycle number: first repeat DLY cycles after a press, then every RATE.
    int m_col, m_row, m_dir, m_next, m_t;
    bit m_hist[4];
    bit m_move, m_blocked, m_goal;
    int dcol[4] = '{0, 0, -1, 1};   // up, down, left, right
    int drow[4] = '{-1, 1, 0, 0};

    task automatic model_hop(input int d);
        int nc, nr;
        nc = m_col + dcol[d];
        nr = m_row + drow[d];
        if (nc < 0 || nc >= COLS || nr < 0 || nr >= ROWS) begin
            m_blocked = 1'b1;
        end else begin
            m_col  = nc;
            m_row  = nr;
            m_move = 1'b1;
            m_goal = (nr == 0);
        end
    endtask

    task automatic model_step(input bit up, input bit down, input bit left, input bit right,
                              input bit en, input bit resp, input bit rst);
        bit key[4];
        int first;
        key[0] = up; key[1] = down; key[2] = left; key[3] = right;
        m_move = 0; m_blocked = 0; m_goal = 0;
        if (rst) begin
            m_col = SC; m_row = SR; m_dir = -1;
            for (int d = 0; d < 4; d++) m_hist[d] = 1'b0;
        end else begin
            first = -1;
            for (int d = 0; d < 4; d++)
                if (first < 0 && key[d] && !m_hist[d]) first = d;
            if (resp) begin
                m_col = SC; m_row = SR; m_dir = -1;
            end else if (!en) begin
                m_dir = -1;
            end else if (first >= 0) begin
                model_hop(first);
                m_dir  = first;
                m_next = m_t + DLY;
            end else if (m_dir >= 0) begin
                if (!key[m_dir]) begin
                    m_dir = -1;
                end else if (m_t == m_next) begin
                    model_hop(m_dir);
                    m_next = m_t + RATE;
                end
            end
            for (int d = 0; d < 4; d++) m_hist[d] = key[d];
        end
        m_t++;
    endtask

    // ---------------- driver ----------------
    // Applies one cycle of inputs, advances the model, and returns 1 time unit
    // after the sampling edge so outputs are stable for comparison.
    task automatic drive(input bit up, input bit down, input bit left, input bit right,
                         input bit en, input bit resp, input bit rst);
        i_Up = up; i_Down = down; i_Left = left; i_Right = right;
        i_Enable = en; i_Respawn = resp; i_Reset = rst;
        model_step(up, down, left, right, en, resp, rst);
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(1, 0, 1, 0, 1, 0, 1);
        drive(0, 0, 0, 0, 1, 0, 1);
        checks++; if (o_Col !== 5'd10) begin failures++; $display("FAIL reset_col got=%0d exp=10", o_Col); end
        checks++; if (o_Row !== 4'd12) begin failures++; $display("FAIL reset_row got=%0d exp=12", o_Row); end
        checks++; if (o_X_Position !== 9'd160) begin failures++; $display("FAIL reset_x got=%0d exp=160", o_X_Position); end
        checks++; if (o_Y_Position !== 9'd192) begin failures++; $display("FAIL reset_y got=%0d exp=192", o_Y_Position); end
        checks++; if ({o_Move_Pulse, o_Blocked, o_Goal} !== 3'b000) begin failures++; $display("FAIL reset_pulses got=%b exp=000", {o_Move_Pulse, o_Blocked, o_Goal}); end
        checks++; if (o_Fsm_State !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", o_Fsm_State); end
    endtask

    task automatic test_single_hop();
        drive(1, 0, 0, 0, 1, 0, 0);
        checks++; if (o_Row !== 4'd11) begin failures++; $display("FAIL hop_row got=%0d exp=11", o_Row); end
        checks++; if (o_Y_Position !== 9'd176) begin failures++; $display("FAIL hop_y got=%0d exp=176", o_Y_Position); end
        checks++; if (o_Move_Pulse !== 1'b1) begin failures++; $display("FAIL hop_pulse got=%b exp=1", o_Move_Pulse); end
        checks++; if (o_Col !== 5'd10) begin failures++; $display("FAIL hop_col got=%0d exp=10", o_Col); end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 1, 0, 0);
            checks++; if (o_Move_Pulse !== 1'b0) begin failures++; $display("FAIL hop_pulse_len cyc=%0d got=%b exp=0", i, o_Move_Pulse); end
        end
        checks++; if (o_Row !== 4'd11) begin failures++; $display("FAIL hop_row_hold got=%0d exp=11", o_Row); end
    endtask

    task automatic test_repeat();
        bit exp_mv;
        for (int i = 0; i < 12; i++) begin
            drive(0, 0, 0, 1, 1, 0, 0);
            exp_mv = (i == 0 || i == 4 || i == 6 || i == 8 || i == 10);
            checks++; if (o_Move_Pulse !== exp_mv) begin failures++; $display("FAIL repeat_pulse cyc=%0d got=%b exp=%b", i + 1, o_Move_Pulse, exp_mv); end
        end
        checks++; if (o_Col !== 5'd15) begin failures++; $display("FAIL repeat_col got=%0d exp=15", o_Col); end
        checks++; if (o_X_Position !== 9'd240) begin failures++; $display("FAIL repeat_x got=%0d exp=240", o_X_Position); end
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 0, 1, 0, 0);
            checks++; if (o_Move_Pulse !== 1'b0) begin failures++; $display("FAIL release_pulse cyc=%0d got=%b exp=0", i, o_Move_Pulse); end
        end
        checks++; if (o_Col !== 5'd15) begin failures++; $display("FAIL release_col got=%0d exp=15", o_Col); end
        checks++; if (o_Fsm_State !== 2'd0) begin failures++; $display("FAIL release_state got=%0d exp=0", o_Fsm_State); end
    endtask

    task automatic test_clamp();
        int moves = 0;
        for (int i = 0; i < 15; i++) begin
            drive(0, 0, 1, 0, 1, 0, 0);
            moves += int'(o_Move_Pulse);
            drive(0, 0, 0, 0, 1, 0, 0);
        end
        checks++; if (moves != 15) begin failures++; $display("FAIL clamp_left_moves got=%0d exp=15", moves); end
        checks++; if (o_Col !== 5'd0) begin failures++; $display("FAIL clamp_col0 got=%0d exp=0", o_Col); end
        drive(0, 0, 1, 0, 1, 0, 0);
        checks++; if (o_Col !== 5'd0) begin failures++; $display("FAIL clamp_left_col got=%0d exp=0", o_Col); end
        checks++; if (o_Blocked !== 1'b1) begin failures++; $display("FAIL clamp_left_blocked got=%b exp=1", o_Blocked); end
        checks++; if (o_Move_Pulse !== 1'b0) begin failures++; $display("FAIL clamp_left_move got=%b exp=0", o_Move_Pulse); end
        drive(0, 0, 0, 0, 1, 0, 0);
        checks++; if (o_Blocked !== 1'b0) begin failures++; $display("FAIL clamp_blocked_len got=%b exp=0", o_Blocked); end
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 1, 0, 0);
            drive(0, 0, 0, 0, 1, 0, 0);
        end
        checks++; if (o_Row !== 4'd14) begin failures++; $display("FAIL clamp_row14 got=%0d exp=14", o_Row); end
        drive(0, 1, 0, 0, 1, 0, 0);
        checks++; if (o_Row !== 4'd14 || o_Blocked !== 1'b1 || o_Move_Pulse !== 1'b0) begin
            failures++; $display("FAIL clamp_down row=%0d blk=%b mv=%b exp row=14 blk=1 mv=0", o_Row, o_Blocked, o_Move_Pulse);
        end
        drive(0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_simultaneous();
        bit exp_mv;
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 1, 1, 0, 0);
            drive(0, 0, 0, 0, 1, 0, 0);
        end
        checks++; if (o_Col !== 5'd2) begin failures++; $display("FAIL simul_setup_col got=%0d exp=2", o_Col); end
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 1, 0, 1, 0, 0);
            exp_mv = (i == 0 || i == 4 || i == 6);
            checks++; if (o_Move_Pulse !== exp_mv || o_Blocked !== 1'b0) begin
                failures++; $display("FAIL simul_pulse cyc=%0d mv=%b blk=%b exp mv=%b blk=0", i, o_Move_Pulse, o_Blocked, exp_mv);
            end
            checks++; if (o_Col !== 5'd2) begin failures++; $display("FAIL simul_col cyc=%0d got=%0d exp=2", i, o_Col); end
        end
        checks++; if (o_Row !== 4'd11) begin failures++; $display("FAIL simul_row got=%0d exp=11", o_Row); end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 1, 0, 0);
            checks++; if (o_Move_Pulse !== 1'b0 || o_Col !== 5'd2) begin
                failures++; $display("FAIL simul_no_replay cyc=%0d mv=%b col=%0d exp mv=0 col=2", i, o_Move_Pulse, o_Col);
            end
        end
    endtask

    task automatic test_goal_respawn();
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 0, 0, 1, 0, 0);
            drive(0, 0, 0, 0, 1, 0, 0);
        end
        checks++; if (o_Row !== 4'd1) begin failures++; $display("FAIL goal_setup_row got=%0d exp=1", o_Row); end
        drive(1, 0, 0, 0, 1, 0, 0);
        checks++; if (o_Row !== 4'd0 || o_Y_Position !== 9'd0) begin failures++; $display("FAIL goal_row row=%0d y=%0d exp 0", o_Row, o_Y_Position); end
        checks++; if (o_Goal !== 1'b1 || o_Move_Pulse !== 1'b1) begin failures++; $display("FAIL goal_pulse goal=%b mv=%b exp 1 1", o_Goal, o_Move_Pulse); end
        for (int i = 1; i < 5; i++) begin
            drive(1, 0, 0, 0, 1, 0, 0);
            checks++; if (o_Goal !== 1'b0 || o_Move_Pulse !== 1'b0 || o_Blocked !== (i == 4)) begin
                failures++; $display("FAIL goal_hold cyc=%0d goal=%b mv=%b blk=%b exp 0 0 %b", i, o_Goal, o_Move_Pulse, o_Blocked, (i == 4));
            end
            checks++; if (o_Row !== 4'd0) begin failures++; $display("FAIL goal_hold_row cyc=%0d got=%0d exp=0", i, o_Row); end
        end
        drive(1, 0, 0, 0, 1, 1, 0);
        checks++; if (o_Row !== 4'd12 || o_Col !== 5'd10) begin failures++; $display("FAIL respawn_pos row=%0d col=%0d exp 12 10", o_Row, o_Col); end
        checks++; if (o_X_Position !== 9'd160 || o_Y_Position !== 9'd192) begin failures++; $display("FAIL respawn_xy x=%0d y=%0d exp 160 192", o_X_Position, o_Y_Position); end
        checks++; if ({o_Move_Pulse, o_Blocked, o_Goal} !== 3'b000) begin failures++; $display("FAIL respawn_pulses got=%b exp=000", {o_Move_Pulse, o_Blocked, o_Goal}); end
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 0, 0, 1, 0, 0);
            checks++; if (o_Move_Pulse !== 1'b0 || o_Blocked !== 1'b0 || o_Row !== 4'd12) begin
                failures++; $display("FAIL respawn_hold cyc=%0d mv=%b blk=%b row=%0d exp 0 0 12", i, o_Move_Pulse, o_Blocked, o_Row);
            end
        end
        drive(0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_enable();
        drive(0, 1, 0, 0, 0, 0, 0);
        checks++; if (o_Move_Pulse !== 1'b0 || o_Row !== 4'd12) begin failures++; $display("FAIL en_off_press mv=%b row=%0d exp 0 12", o_Move_Pulse, o_Row); end
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 0, 0, 1, 0, 0);
            checks++; if (o_Move_Pulse !== 1'b0 || o_Row !== 4'd12) begin failures++; $display("FAIL en_held_no_edge cyc=%0d mv=%b row=%0d exp 0 12", i, o_Move_Pulse, o_Row); end
        end
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 1, 0, 0, 1, 0, 0);
        checks++; if (o_Move_Pulse !== 1'b1 || o_Row !== 4'd13) begin failures++; $display("FAIL en_press mv=%b row=%0d exp 1 13", o_Move_Pulse, o_Row); end
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 1, 0, 0, 1, 0, 0);
        drive(0, 1, 0, 0, 1, 0, 0);
        for (int i = 2; i < 12; i++) begin
            drive(0, 1, 0, 0, (i >= 8), 0, 0);
            checks++; if (o_Move_Pulse !== 1'b0 || o_Blocked !== 1'b0) begin
                failures++; $display("FAIL en_drop cyc=%0d mv=%b blk=%b exp 0 0", i, o_Move_Pulse, o_Blocked);
            end
            checks++; if (i < 8 && o_Fsm_State !== 2'd0) begin failures++; $display("FAIL en_drop_state cyc=%0d got=%0d exp=0", i, o_Fsm_State); end
        end
        checks++; if (o_Row !== 4'd14) begin failures++; $display("FAIL en_row got=%0d exp=14", o_Row); end
        drive(0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_random();
        bit k[4];
        bit en = 1'b1;
        int printed = 0;
        for (int d = 0; d < 4; d++) k[d] = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            for (int d = 0; d < 4; d++)
                if ($urandom_range(0, 5) == 0) k[d] = ~k[d];
            if ($urandom_range(0, 29) == 0) en = ~en;
            drive(k[0], k[1], k[2], k[3], en, ($urandom_range(0, 99) == 0), ($urandom_range(0, 499) == 0));
            checks++;
            if (o_Col !== 5'(m_col) || o_Row !== 4'(m_row) ||
                o_X_Position !== 9'(m_col * TILE) || o_Y_Position !== 9'(m_row * TILE) ||
                o_Move_Pulse !== m_move || o_Blocked !== m_blocked || o_Goal !== m_goal) begin
                failures++;
                if (printed < 20) begin
                    printed++;
                    $display("FAIL random cyc=%0d got col=%0d row=%0d x=%0d y=%0d mv=%b blk=%b goal=%b exp col=%0d row=%0d x=%0d y=%0d mv=%b blk=%b goal=%b",
                             n, o_Col, o_Row, o_X_Position, o_Y_Position, o_Move_Pulse, o_Blocked, o_Goal,
                             m_col, m_row, m_col * TILE, m_row * TILE, m_move, m_blocked, m_goal);
                end
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        m_t = 0; m_dir = -1; m_next = 0; m_col = SC; m_row = SR;
        m_move = 0; m_blocked = 0; m_goal = 0;
        for (int d = 0; d < 4; d++) m_hist[d] = 1'b0;
        i_Reset = 1'b1; i_Enable = 1'b1; i_Respawn = 1'b0;
        i_Up = 1'b0; i_Down = 1'b0; i_Left = 1'b0; i_Right = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_hop();
        test_repeat();
        test_clamp();
        test_simultaneous();
        test_goal_respawn();
        test_enable();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout waiting for test sequence");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
